// File: rtl/random_arbiter_pkg.sv
// Shared definitions for the random arbiter: FSM states, LFSR constants
// and the LFSR next-state / seed-sanitizing helpers.
package random_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam logic [2:0] LFSR_RST  = 3'b001;
    localparam logic [2:0] LFSR_LOCK = 3'b111;

    // The all-ones state would lock an XNOR LFSR; it is mapped to 000 instead.
    function automatic logic [2:0] lfsr_sanitize(input logic [2:0] v);
        return (v == LFSR_LOCK) ? 3'b000 : v;
    endfunction

    // One XNOR-LFSR step: next[0] = cur[2] ~^ cur[1], next[1] = cur[0], next[2] = cur[1].
    function automatic logic [2:0] lfsr_next(input logic [2:0] c);
        return {c[1], c[0], ~(c[2] ^ c[1])};
    endfunction

endpackage

// File: rtl/lfsr3_core.sv
// 3-bit XNOR LFSR with load (sanitized seed) and step; load wins over step.
module lfsr3_core
    import random_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       step,
    input  logic       load,
    input  logic [2:0] seed,
    output logic [2:0] value,
    output logic [2:0] next_value
);

    assign next_value = lfsr_next(value);

    // Generator state: reload from seed, or advance one step, otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= LFSR_RST;
        end else if (load) begin
            value <= lfsr_sanitize(seed);
        end else if (step) begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/random_arbiter.sv
// Round-robin arbiter that hands out a fresh LFSR value with every grant.
// A grant lasts one cycle (GRANT state), so at most one grant every two cycles.
module random_arbiter
    import random_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       seed,
    input  logic             load,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             valid,
    output logic [2:0]       rnd_out,
    output logic [7:0]       grant_cnt
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e    state;
    logic [PW-1:0] ptr;        // where the next round-robin search starts
    logic [PW-1:0] win_idx;
    logic          win_found;
    logic          step;
    logic [2:0]    lfsr_value;
    logic [2:0]    lfsr_next_value;

    // A new grant is started only from IDLE when no reload is pending.
    assign step = (state == ST_IDLE) && !load && (|req);

    // LOAD is honoured in either state: in IDLE it blocks the grant, in GRANT
    // it lands on the GRANT->IDLE edge without disturbing the grant in flight.
    lfsr3_core u_lfsr (
        .clk        (clk),
        .reset_n    (reset_n),
        .step       (step),
        .load       (load),
        .seed       (seed),
        .value      (lfsr_value),
        .next_value (lfsr_next_value)
    );

    // Round-robin search: first requester at or after ptr, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    // FSM, grant outputs, round-robin pointer and grant counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            gnt       <= '0;
            valid     <= 1'b0;
            rnd_out   <= 3'b000;
            grant_cnt <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (step && win_found) begin
                        state   <= ST_GRANT;
                        gnt     <= N_REQ'(1) << win_idx;
                        valid   <= 1'b1;
                        rnd_out <= lfsr_next_value;
                        ptr     <= (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
                    end
                end
                ST_GRANT: begin
                    state     <= ST_IDLE;
                    gnt       <= '0;
                    valid     <= 1'b0;
                    grant_cnt <= grant_cnt + 8'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_random_arbiter.sv
// Directed testbench for random_arbiter (N_REQ = 4).
module tb_random_arbiter;

    logic       clk;
    logic       reset_n;
    logic [2:0] seed;
    logic       load;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       valid;
    logic [2:0] rnd_out;
    logic [7:0] grant_cnt;

    int checks;
    int errors;

    random_arbiter #(.N_REQ(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .seed      (seed),
        .load      (load),
        .req       (req),
        .gnt       (gnt),
        .valid     (valid),
        .rnd_out   (rnd_out),
        .grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR sequence starting from 001 (period 7).
    function automatic logic [2:0] seq_val(input int k);
        case (k % 7)
            0: return 3'b001;
            1: return 3'b011;
            2: return 3'b110;
            3: return 3'b101;
            4: return 3'b010;
            5: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        load    = 1'b0;
        seed    = 3'b000;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (gnt !== 4'b0000 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt_valid gnt=%b valid=%b want 0000/0", gnt, valid);
        end
        checks++;
        if (rnd_out !== 3'b000 || grant_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_rnd_cnt rnd=%b cnt=%0d want 000/0", rnd_out, grant_cnt);
        end
    endtask

    task automatic test_single();
        logic [2:0] exp_rnd [0:2];
        exp_rnd[0] = 3'b011; exp_rnd[1] = 3'b110; exp_rnd[2] = 3'b101;
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (gnt !== 4'b0001 || valid !== 1'b1 || rnd_out !== exp_rnd[i]) begin
                errors++;
                $display("FAIL single_grant%0d gnt=%b valid=%b rnd=%b want 0001/1/%b",
                         i, gnt, valid, rnd_out, exp_rnd[i]);
            end
            tick();
            checks++;
            if (gnt !== 4'b0000 || valid !== 1'b0 || rnd_out !== exp_rnd[i]) begin
                errors++;
                $display("FAIL single_idle%0d gnt=%b valid=%b rnd=%b want 0000/0/%b",
                         i, gnt, valid, rnd_out, exp_rnd[i]);
            end
        end
        checks++;
        if (grant_cnt !== 8'd3) begin
            errors++;
            $display("FAIL single_cnt cnt=%0d want 3", grant_cnt);
        end
        // Idle cycles must not advance the generator.
        req = 4'b0000;
        tick(); tick(); tick();
        req = 4'b0001;
        tick();
        checks++;
        if (valid !== 1'b1 || rnd_out !== 3'b010) begin
            errors++;
            $display("FAIL idle_no_step valid=%b rnd=%b want 1/010", valid, rnd_out);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (grant_cnt !== 8'd4) begin
            errors++;
            $display("FAIL single_cnt4 cnt=%0d want 4", grant_cnt);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt [0:4];
        exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
        exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (gnt !== exp_gnt[i] || valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant%0d gnt=%b valid=%b want %b/1", i, gnt, valid, exp_gnt[i]);
            end
            tick();
            checks++;
            if (valid !== 1'b0 || gnt !== 4'b0000) begin
                errors++;
                $display("FAIL rr_gap%0d gnt=%b valid=%b want 0000/0", i, gnt, valid);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_load_lockup();
        do_reset();
        load = 1'b1;
        seed = 3'b111;
        req  = 4'b0100;
        tick();
        checks++;
        if (valid !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL load_no_grant gnt=%b valid=%b want 0000/0", gnt, valid);
        end
        load = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0100 || valid !== 1'b1 || rnd_out !== 3'b001) begin
            errors++;
            $display("FAIL load_lockup gnt=%b valid=%b rnd=%b want 0100/1/001", gnt, valid, rnd_out);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_load_in_grant();
        do_reset();
        req = 4'b0001;
        tick();
        load = 1'b1;
        seed = 3'b101;
        #1;
        checks++;
        if (gnt !== 4'b0001 || rnd_out !== 3'b011) begin
            errors++;
            $display("FAIL load_in_grant_inflight gnt=%b rnd=%b want 0001/011", gnt, rnd_out);
        end
        tick();
        load = 1'b0;
        checks++;
        if (valid !== 1'b0 || rnd_out !== 3'b011) begin
            errors++;
            $display("FAIL load_in_grant_idle valid=%b rnd=%b want 0/011", valid, rnd_out);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || rnd_out !== 3'b010) begin
            errors++;
            $display("FAIL load_in_grant_next valid=%b rnd=%b want 1/010", valid, rnd_out);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0001;
        tick(); tick(); tick();   // second grant now in flight
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || valid !== 1'b0 || grant_cnt !== 8'd0 || rnd_out !== 3'b000) begin
            errors++;
            $display("FAIL async_reset gnt=%b valid=%b cnt=%0d rnd=%b want 0000/0/0/000",
                     gnt, valid, grant_cnt, rnd_out);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b1 || rnd_out !== 3'b011) begin
            errors++;
            $display("FAIL after_reset_grant valid=%b rnd=%b want 1/011", valid, rnd_out);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (grant_cnt !== 8'd1) begin
            errors++;
            $display("FAIL after_reset_cnt cnt=%0d want 1", grant_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] one = 4'b0001;
        logic [3:0] eg;
        logic [2:0] er;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 260; i++) begin
            tick();
            eg = one << (i % 4);
            er = seq_val(i + 1);
            checks++;
            if (gnt !== eg || valid !== 1'b1 || rnd_out !== er || rnd_out === 3'b111) begin
                errors++;
                $display("FAIL wrap_grant%0d gnt=%b valid=%b rnd=%b want %b/1/%b",
                         i, gnt, valid, rnd_out, eg, er);
            end
            tick();
        end
        req = 4'b0000;
        checks++;
        if (grant_cnt !== 8'd4) begin
            errors++;
            $display("FAIL wrap_cnt cnt=%0d want 4", grant_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_load_lockup();
        test_load_in_grant();
        test_reset_mid_grant();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
